feed_bus_arbiter: RTL
=====================

Name: feed_bus_arbiter

Overview:
- Shares one execution unit's feed bus between REQ_CNT reservation stations.
- Each cycle, selects one ready station using round-robin, returns a one-hot grant to it, and registers that station's operands into an output stage.
- The output stage drives the execution unit (station-side signals of the feed bus) and holds until the unit accepts.
- Sits between the reservation stations and one execution unit; typically shared by ALU and branch stations, or used in front of a multi-cycle mul/div unit.

Parameters:
- REQ_CNT, 2, number of requesting stations (2..8).
- PTR_W, $clog2(REQ_CNT) (min 1), width of the round-robin pointer (derived).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  pipeline flush (mispredict); drops the held instruction
- req_valid  input  REQ_CNT  station i has an issuable instruction
- req_data_1  input  REQ_CNT x XLEN  operand 1 per station
- req_data_2  input  REQ_CNT x XLEN  operand 2 per station
- req_address  input  REQ_CNT x XLEN  instruction address per station
- req_immediate  input  REQ_CNT x XLEN  immediate per station
- req_instr_name  input  REQ_CNT x instr_name_e  decoded op per station
- req_rrn  input  REQ_CNT x 6  destination rename register per station
- grant  output  REQ_CNT  one-hot, combinational; station i's entry is consumed this cycle
- exec_ready  input  1  execution unit accepts the output stage this cycle
- out_valid  output  1  output stage holds a valid instruction
- data_1, data_2, address, immediate  output  XLEN each  feed bus fields
- instr_name  output  instr_name_e  feed bus op
- rrn  output  6  feed bus destination tag

Behaviour:
- Reset (sync, high), effective next edge:
  - out_valid=0
  - all data outputs 0; instr_name = enum value 0
  - rr_ptr=0
  - grant=0 combinationally while reset is high
- Reset mid-HOLD discards the held instruction. No grant is issued.
- States:
  - EMPTY (out_valid=0)
  - HOLD (out_valid=1)
- Slot free (slot_free) = !out_valid | exec_ready.
- Grant:
  - When slot_free & !flush & !reset & |req_valid, grant the first i with req_valid[i], searching rr_ptr, rr_ptr+1, … mod REQ_CNT.
  - Otherwise grant=0.
  - Grant is at most one-hot and always a subset of req_valid.
- Handshake (station side):
  - Station holds req_valid and its fields stable until granted.
  - The grant cycle is the consume cycle; the station must drop or replace the entry next cycle.
- On grant to station k, at the clock edge:
  - Output fields load from station k.
  - out_valid=1 (HOLD).
  - rr_ptr=(k+1) mod REQ_CNT.
- Transitions:
  - EMPTY→HOLD on grant.
  - HOLD & exec_ready & grant → HOLD with new contents. Back-to-back issue gives one instruction per cycle.
  - HOLD & exec_ready & no grant → EMPTY.
  - HOLD & !exec_ready → HOLD. Fields and out_valid are held bit-stable; grant=0.
- Latency: request to out_valid is exactly 1 cycle when the slot is free.
- Flush:
  - Next state is EMPTY; out_valid=0.
  - No grant that cycle, even if exec_ready.
  - rr_ptr unchanged.
  - Flush has priority over exec_ready and grant.
- Output data fields hold their last value when EMPTY; consumers qualify with out_valid.
- Fairness: a continuously requesting station is granted within REQ_CNT grants.
- Wrap-around: rr_ptr after granting REQ_CNT-1 becomes 0.

Optional Feature:
- Macro: FEED_BUS_ARBITER_STATS_EN.
- With the macro defined, adds two outputs:
  - stall_cnt (32 bits): increments each cycle out_valid & !exec_ready & !flush.
  - grant_cnt (REQ_CNT x 32 bits): entry i increments on grant[i].
  - Both saturate at all-ones and clear on reset.
- Without the macro: ports and counters are absent; the remaining behaviour is identical.

Test Plan:
- Reset, then req_valid=2'b01 with data_1=32'h1234, rrn=6'd5, exec_ready=1 → grant=2'b01 that cycle; next cycle out_valid=1, data_1=32'h1234, rrn=5; rr_ptr=1.
- Both stations requesting continuously, exec_ready=1, for 6 cycles → grants alternate 10,01,10,01,10,01 (starting from rr_ptr=1); one out_valid per cycle, with fields matching the granted station.
- HOLD with exec_ready=0 for 3 cycles while req_valid=2'b11 → grant=0 for all 3 cycles; outputs unchanged; on exec_ready=1, the next station in rr order is granted that same cycle.
- HOLD with rrn=9, then flush=1 with exec_ready=1 and req_valid=2'b10 → grant=0; next cycle out_valid=0; rr_ptr unchanged; the following cycle grants 2'b10.
- Reset asserted while in HOLD with req_valid=2'b11 → grant=0; next cycle out_valid=0, rr_ptr=0, all outputs 0; the first grant after release is 2'b01.
- STATS_EN build: 4 stall cycles plus 3 grants to station 0 → stall_cnt=4, grant_cnt[0]=3, grant_cnt[1]=0; counter forced to 32'hFFFFFFFF stays there on the next event.

Source files
------------

// File: rtl/feed_bus_arbiter.sv
// Round-robin arbiter that hands one execution unit's feed bus to REQ_CNT reservation stations
// through a registered output stage. Define FEED_BUS_ARBITER_STATS_EN to add stall/grant counters.
package feed_bus_arbiter_pkg;
  typedef enum logic [4:0] {
    INSTR_NOP = 5'd0,
    INSTR_ADD,
    INSTR_SUB,
    INSTR_AND,
    INSTR_OR,
    INSTR_XOR,
    INSTR_SLL,
    INSTR_SRL,
    INSTR_BEQ,
    INSTR_BNE,
    INSTR_MUL,
    INSTR_DIV
  } instr_name_e;
endpackage

module feed_bus_arbiter
  import feed_bus_arbiter_pkg::*;
#(
  parameter  int REQ_CNT = 2,
  parameter  int XLEN    = 32,
  localparam int PTR_W   = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [REQ_CNT-1:0]            req_valid,
  input  logic [REQ_CNT-1:0][XLEN-1:0]  req_data_1,
  input  logic [REQ_CNT-1:0][XLEN-1:0]  req_data_2,
  input  logic [REQ_CNT-1:0][XLEN-1:0]  req_address,
  input  logic [REQ_CNT-1:0][XLEN-1:0]  req_immediate,
  input  instr_name_e [REQ_CNT-1:0]     req_instr_name,
  input  logic [REQ_CNT-1:0][5:0]       req_rrn,
  output logic [REQ_CNT-1:0]            grant,
  input  logic                          exec_ready,
  output logic                          out_valid,
  output logic [XLEN-1:0]               data_1,
  output logic [XLEN-1:0]               data_2,
  output logic [XLEN-1:0]               address,
  output logic [XLEN-1:0]               immediate,
  output instr_name_e                   instr_name,
  output logic [5:0]                    rrn
`ifdef FEED_BUS_ARBITER_STATS_EN
  ,
  output logic [31:0]                   stall_cnt,
  output logic [REQ_CNT-1:0][31:0]      grant_cnt
`endif
);

  typedef enum logic {ST_EMPTY, ST_HOLD} state_e;

  typedef struct packed {
    logic [XLEN-1:0] data_1;
    logic [XLEN-1:0] data_2;
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] immediate;
    instr_name_e     instr_name;
    logic [5:0]      rrn;
  } feed_t;

  state_e           state_q, state_d;
  feed_t            feed_q, feed_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] win_idx;
  logic             win_found;
  logic             slot_free;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= REQ_CNT) sum = sum - REQ_CNT;
    return PTR_W'(sum);
  endfunction

  assign slot_free = (state_q == ST_EMPTY) || exec_ready;

  // Scan stations starting at rr_ptr; the first ready one wins.
  always_comb begin : arbitrate
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    grant     = '0;
    win_idx   = rr_ptr_q;
    win_found = 1'b0;
    if (slot_free && !flush && !reset) begin
      for (int n = 0; n < REQ_CNT; n++) begin
        if (!win_found && req_valid[wrap_add(rr_ptr_q, n)]) begin
          win_found = 1'b1;
          win_idx   = wrap_add(rr_ptr_q, n);
        end
      end
      if (win_found) grant[win_idx] = 1'b1;
    end
  end

  // Flush beats everything; otherwise a grant reloads, and a consumed stage with no grant empties.
  always_comb begin : next_state
    state_d  = state_q;
    feed_d   = feed_q;
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (win_found) begin
      state_d           = ST_HOLD;
      feed_d.data_1     = req_data_1[win_idx];
      feed_d.data_2     = req_data_2[win_idx];
      feed_d.address    = req_address[win_idx];
      feed_d.immediate  = req_immediate[win_idx];
      feed_d.instr_name = req_instr_name[win_idx];
      feed_d.rrn        = req_rrn[win_idx];
      rr_ptr_d          = wrap_add(win_idx, 1);
    end else if (exec_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values regardless of block order.
    if (reset) begin
      state_q  <= ST_EMPTY;
      feed_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      feed_q   <= feed_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_valid  = (state_q == ST_HOLD);
  assign data_1     = feed_q.data_1;
  assign data_2     = feed_q.data_2;
  assign address    = feed_q.address;
  assign immediate  = feed_q.immediate;
  assign instr_name = feed_q.instr_name;
  assign rrn        = feed_q.rrn;

`ifdef FEED_BUS_ARBITER_STATS_EN
  logic [31:0]              stall_cnt_q, stall_cnt_d;
  logic [REQ_CNT-1:0][31:0] grant_cnt_q, grant_cnt_d;

  // Saturating event counters.
  always_comb begin : stats_next
    stall_cnt_d = stall_cnt_q;
    grant_cnt_d = grant_cnt_q;
    if (out_valid && !exec_ready && !flush && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    for (int i = 0; i < REQ_CNT; i++) begin
      if (grant[i] && (grant_cnt_q[i] != '1)) grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      grant_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign grant_cnt = grant_cnt_q;
`endif

endmodule
